// File: rtl/alu_cmd_issuer.sv
// Command FIFO feeding a multi-cycle ALU: queues {op,a,b}, issues one command at
// a time through LOAD/EXEC, and holds each result in RESP until it is consumed.
module alu_cmd_issuer #(
  parameter int DEPTH       = 4,
  parameter int EXEC_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [6:0]               cmd_op,
  input  logic [7:0]               cmd_a,
  input  logic [7:0]               cmd_b,
  output logic                     alu_on,
  output logic [2:0]               alu_in_sel,
  output logic [7:0]               alu_num1,
  output logic [7:0]               alu_num2,
  output logic [6:0]               alu_out_sel,
  input  logic [7:0]               alu_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [7:0]               res_data,
  output logic [6:0]               res_op,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [2:0] SEL_NONE    = 3'b000;
  localparam logic [2:0] SEL_LOAD    = 3'b010;
  localparam logic [2:0] SEL_PERSIST = 3'b100;

  typedef struct packed {
    logic [6:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    EXEC = 2'b10,
    RESP = 2'b11
  } state_t;

  cmd_t [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  cmd_t             head;
  logic             push, pop;

  state_t           state_q;
  logic [2:0]       exec_cnt_q;
  logic             alu_on_q;
  logic [2:0]       alu_in_sel_q;
  logic [7:0]       alu_num1_q, alu_num2_q;
  logic [6:0]       alu_out_sel_q;
  logic             res_valid_q;
  logic [7:0]       res_data_q;
  logic [6:0]       res_op_q;

  // Ready depends on occupancy alone, so a full FIFO never accepts on the pop edge.
  assign cmd_ready = (count_q < CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (count_q != '0) &&
                     ((state_q == IDLE) || ((state_q == RESP) && res_ready));
  assign head      = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{op: cmd_op, a: cmd_a, b: cmd_b};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      exec_cnt_q    <= '0;
      alu_on_q      <= 1'b0;
      alu_in_sel_q  <= SEL_NONE;
      alu_num1_q    <= '0;
      alu_num2_q    <= '0;
      alu_out_sel_q <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_op_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            state_q       <= LOAD;
            alu_on_q      <= 1'b1;
            alu_in_sel_q  <= SEL_LOAD;
            alu_num1_q    <= head.a;
            alu_num2_q    <= head.b;
            alu_out_sel_q <= head.op;
          end
        end
        LOAD: begin
          state_q      <= EXEC;
          alu_in_sel_q <= SEL_PERSIST;
          exec_cnt_q   <= '0;
        end
        EXEC: begin
          // alu_out is sampled on the edge closing the last persist cycle.
          if (exec_cnt_q == 3'(EXEC_CYCLES - 1)) begin
            state_q     <= RESP;
            res_valid_q <= 1'b1;
            res_data_q  <= alu_out;
            res_op_q    <= alu_out_sel_q;
          end else begin
            exec_cnt_q <= exec_cnt_q + 3'd1;
          end
        end
        RESP: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            if (pop) begin
              state_q       <= LOAD;
              alu_in_sel_q  <= SEL_LOAD;
              alu_num1_q    <= head.a;
              alu_num2_q    <= head.b;
              alu_out_sel_q <= head.op;
            end else begin
              state_q      <= IDLE;
              alu_on_q     <= 1'b0;
              alu_in_sel_q <= SEL_NONE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign state       = state_q;
  assign count       = count_q;
  assign alu_on      = alu_on_q;
  assign alu_in_sel  = alu_in_sel_q;
  assign alu_num1    = alu_num1_q;
  assign alu_num2    = alu_num2_q;
  assign alu_out_sel = alu_out_sel_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_op      = res_op_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with an adder as the ALU (num1 + num2 mod 256).
module tb_alu_cmd_issuer;

  localparam int DEPTH = 4;
  localparam int EXEC_CYCLES = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [6:0] cmd_op;
  logic [7:0] cmd_a, cmd_b;
  logic       alu_on;
  logic [2:0] alu_in_sel;
  logic [7:0] alu_num1, alu_num2;
  logic [6:0] alu_out_sel;
  logic [7:0] alu_out;
  logic       res_valid, res_ready;
  logic [7:0] res_data;
  logic [6:0] res_op;
  logic [1:0] state;
  logic [2:0] count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign alu_out = alu_num1 + alu_num2;

  alu_cmd_issuer #(.DEPTH(DEPTH), .EXEC_CYCLES(EXEC_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_on(alu_on), .alu_in_sel(alu_in_sel),
    .alu_num1(alu_num1), .alu_num2(alu_num2), .alu_out_sel(alu_out_sel),
    .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_op(res_op),
    .state(state), .count(count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; res_ready = 1'b0;
    #3;
    tests++; if (state !== 2'b00)     begin fails++; $display("FAIL reset_state got %b exp 00", state); end
    tests++; if (count !== 3'd0)      begin fails++; $display("FAIL reset_count got %0d exp 0", count); end
    tests++; if (cmd_ready !== 1'b1)  begin fails++; $display("FAIL reset_ready got %b exp 1", cmd_ready); end
    tests++; if ({res_valid, alu_on, alu_in_sel, alu_num1, alu_num2, alu_out_sel, res_data, res_op} !== '0)
      begin fails++; $display("FAIL reset_outputs got nonzero rv=%b on=%b sel=%b n1=%h n2=%h", res_valid, alu_on, alu_in_sel, alu_num1, alu_num2); end
    @(negedge clk); rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    res_ready = 1'b1;
    cmd_valid = 1'b1; cmd_op = 7'b0001000; cmd_a = 8'h57; cmd_b = 8'h1A;
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL single_ready got %b exp 1", cmd_ready); end
    tick();
    cmd_valid = 1'b0;
    tests++; if (state !== 2'b00 || count !== 3'd1) begin fails++; $display("FAIL single_accept state=%b count=%0d exp 00/1", state, count); end
    tick();
    tests++; if (state !== 2'b01 || alu_in_sel !== 3'b010 || alu_on !== 1'b1)
      begin fails++; $display("FAIL single_load state=%b sel=%b on=%b exp 01/010/1", state, alu_in_sel, alu_on); end
    tests++; if (alu_num1 !== 8'h57 || alu_num2 !== 8'h1A || alu_out_sel !== 7'b0001000)
      begin fails++; $display("FAIL single_operands n1=%h n2=%h op=%b exp 57/1a/0001000", alu_num1, alu_num2, alu_out_sel); end
    tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL single_early_valid got %b exp 0", res_valid); end
    tick();
    tests++; if (state !== 2'b10 || alu_in_sel !== 3'b100 || res_valid !== 1'b0)
      begin fails++; $display("FAIL single_exec state=%b sel=%b rv=%b exp 10/100/0", state, alu_in_sel, res_valid); end
    tick();
    tests++; if (state !== 2'b11 || res_valid !== 1'b1 || alu_in_sel !== 3'b100 || alu_on !== 1'b1)
      begin fails++; $display("FAIL single_resp state=%b rv=%b sel=%b on=%b exp 11/1/100/1", state, res_valid, alu_in_sel, alu_on); end
    tests++; if (res_data !== 8'h71 || res_op !== 7'b0001000)
      begin fails++; $display("FAIL single_result data=%h op=%b exp 71/0001000", res_data, res_op); end
    tick();
    tests++; if (state !== 2'b00 || res_valid !== 1'b0 || alu_on !== 1'b0 || alu_in_sel !== 3'b000)
      begin fails++; $display("FAIL single_idle state=%b rv=%b on=%b sel=%b exp 00/0/0/000", state, res_valid, alu_on, alu_in_sel); end
    tests++; if (alu_num1 !== 8'h57) begin fails++; $display("FAIL single_retain n1=%h exp 57", alu_num1); end
  endtask

  task automatic test_fill();
    logic [7:0] got[$];
    int cyc;
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd_op = 7'(i); cmd_a = 8'(8'h10 + i); cmd_b = 8'h01;
      tick();
    end
    tests++; if (count !== 3'd4 || cmd_ready !== 1'b0)
      begin fails++; $display("FAIL fill_full count=%0d ready=%b exp 4/0", count, cmd_ready); end
    tests++; if (state !== 2'b11 || res_data !== 8'h11)
      begin fails++; $display("FAIL fill_first state=%b data=%h exp 11/11", state, res_data); end
    cmd_op = 7'd5; cmd_a = 8'h15;
    for (int i = 0; i < 3; i++) tick();
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL fill_held count=%0d exp 4", count); end
    res_ready = 1'b1;
    tick();
    tests++; if (count !== 3'd3 || state !== 2'b01 || cmd_ready !== 1'b1)
      begin fails++; $display("FAIL fill_pop count=%0d state=%b ready=%b exp 3/01/1", count, state, cmd_ready); end
    tick();
    cmd_valid = 1'b0;
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL fill_sixth count=%0d exp 4", count); end
    cyc = 0;
    while (got.size() < 5 && cyc < 100) begin
      if (res_valid && res_ready) got.push_back(res_data);
      tick(); cyc++;
    end
    tests++; if (got.size() != 5) begin fails++; $display("FAIL fill_drain_count got %0d exp 5", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      tests++; if (got[i] !== 8'(8'h12 + i)) begin fails++; $display("FAIL fill_order[%0d] got %h exp %h", i, got[i], 8'(8'h12 + i)); end
    end
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_backpressure();
    int cyc;
    res_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = 7'h22; cmd_a = 8'h00; cmd_b = 8'h01;
    tick();
    cmd_valid = 1'b0;
    cyc = 0;
    while (state !== 2'b11 && cyc < 20) begin tick(); cyc++; end
    tests++; if (state !== 2'b11) begin fails++; $display("FAIL bp_reach_resp timeout state=%b", state); end
    cmd_valid = 1'b1; cmd_op = 7'h23; cmd_a = 8'h02; cmd_b = 8'h03;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tests++; if (state !== 2'b11 || res_valid !== 1'b1 || res_data !== 8'h01 || res_op !== 7'h22)
        begin fails++; $display("FAIL bp_hold[%0d] state=%b rv=%b data=%h op=%h exp 11/1/01/22", i, state, res_valid, res_data, res_op); end
      tick();
    end
    tests++; if (count !== 3'd1) begin fails++; $display("FAIL bp_queued count=%0d exp 1", count); end
    res_ready = 1'b1;
    tick();
    tests++; if (state !== 2'b01 || res_valid !== 1'b0 || alu_num1 !== 8'h02 || count !== 3'd0)
      begin fails++; $display("FAIL bp_next_load state=%b rv=%b n1=%h count=%0d exp 01/0/02/0", state, res_valid, alu_num1, count); end
    cyc = 0;
    while (res_valid !== 1'b1 && cyc < 20) begin tick(); cyc++; end
    tests++; if (res_data !== 8'h05 || res_op !== 7'h23)
      begin fails++; $display("FAIL bp_second data=%h op=%h exp 05/23", res_data, res_op); end
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_wrap();
    logic [7:0] got[$];
    int sent, cyc;
    res_ready = 1'b1;
    sent = 0; cyc = 0;
    while ((got.size() < 9) && cyc < 300) begin
      if (res_valid && res_ready) got.push_back(res_data);
      if (sent < 9) begin
        cmd_valid = 1'b1; cmd_op = 7'h40; cmd_a = 8'(sent); cmd_b = 8'h01;
      end else cmd_valid = 1'b0;
      if (cmd_valid && cmd_ready) sent++;
      tick(); cyc++;
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (res_valid && res_ready) got.push_back(res_data);
      tick();
    end
    tests++; if (got.size() != 9) begin fails++; $display("FAIL wrap_count got %0d exp 9", got.size()); end
    for (int i = 0; i < got.size() && i < 9; i++) begin
      tests++; if (got[i] !== 8'(i + 1)) begin fails++; $display("FAIL wrap_order[%0d] got %h exp %h", i, got[i], 8'(i + 1)); end
    end
    tests++; if (state !== 2'b00 || count !== 3'd0) begin fails++; $display("FAIL wrap_idle state=%b count=%0d exp 00/0", state, count); end
  endtask

  task automatic test_reset_mid_exec();
    int seen;
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd_op = 7'h11; cmd_a = 8'(8'h30 + i); cmd_b = 8'h05;
      tick();
    end
    cmd_valid = 1'b0;
    tests++; if (state !== 2'b10 || count !== 3'd2)
      begin fails++; $display("FAIL rst_setup state=%b count=%0d exp 10/2", state, count); end
    #2 rst = 1'b0;
    #1;
    tests++; if (state !== 2'b00 || count !== 3'd0 || cmd_ready !== 1'b1)
      begin fails++; $display("FAIL rst_async state=%b count=%0d ready=%b exp 00/0/1", state, count, cmd_ready); end
    tests++; if ({res_valid, alu_on, alu_in_sel, alu_num1, alu_num2, alu_out_sel, res_data, res_op} !== '0)
      begin fails++; $display("FAIL rst_async_outputs rv=%b on=%b sel=%b n1=%h n2=%h op=%h", res_valid, alu_on, alu_in_sel, alu_num1, alu_num2, alu_out_sel); end
    @(negedge clk); rst = 1'b1;
    res_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (res_valid !== 1'b0 || state !== 2'b00) seen++;
    end
    tests++; if (seen != 0) begin fails++; $display("FAIL rst_no_result got %0d active cycles exp 0", seen); end
  endtask

  task automatic test_simultaneous();
    int cyc;
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd_op = 7'h12; cmd_a = 8'(8'h50 + i); cmd_b = 8'h00;
      tick();
    end
    cmd_valid = 1'b0;
    tick();
    tests++; if (state !== 2'b11 || count !== 3'd2)
      begin fails++; $display("FAIL sim_setup state=%b count=%0d exp 11/2", state, count); end
    cmd_valid = 1'b1; cmd_a = 8'h53; res_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tests++; if (count !== 3'd2 || state !== 2'b01 || alu_num1 !== 8'h51)
      begin fails++; $display("FAIL sim_count count=%0d state=%b n1=%h exp 2/01/51", count, state, alu_num1); end
    cyc = 0;
    while ((state !== 2'b00 || count !== 3'd0) && cyc < 100) begin tick(); cyc++; end
    tests++; if (state !== 2'b00 || count !== 3'd0)
      begin fails++; $display("FAIL sim_drain timeout state=%b count=%0d", state, count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_backpressure();
    test_wrap();
    test_reset_mid_exec();
    test_simultaneous();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
